// File: rtl/demux_12_pkg.sv
// Shared defaults and slot identifiers for the registered 1:2 demultiplexer.
package demux_pkg;

    localparam int DEMUX_WIDTH = 4;   // default data word width
    localparam int DEMUX_CNT_W = 8;   // default per-slot delivery counter width
    localparam int NUM_SLOTS   = 2;

    localparam logic SLOT0 = 1'b0;
    localparam logic SLOT1 = 1'b1;

endpackage

// File: rtl/demux_12_if.sv
// Producer/consumer bus of the demultiplexer.
// The slave modport is the demux itself.
// The master modport is the environment, which drives words in and acks slots.
interface demux_12_if
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int CNT_W = DEMUX_CNT_W
);

    logic [WIDTH-1:0] demux_in;
    logic             sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] demux_out0;
    logic [WIDTH-1:0] demux_out1;
    logic             out_valid0;
    logic             out_valid1;
    logic             out_ack0;
    logic             out_ack1;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport slave (
        input  demux_in, sel, in_valid, out_ack0, out_ack1,
        output in_ready, demux_out0, demux_out1, out_valid0, out_valid1, cnt0, cnt1
    );

    modport master (
        output demux_in, sel, in_valid, out_ack0, out_ack1,
        input  in_ready, demux_out0, demux_out1, out_valid0, out_valid1, cnt0, cnt1
    );

endinterface

// File: rtl/demux_12_slot.sv
// One holding slot: a data register, a valid flag and a wrapping delivery counter.
// A load always wins over an ack, so the slot can take one word per cycle.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int CNT_W = DEMUX_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             ack,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic [CNT_W-1:0] cnt
);

    // Load captures the word and counts it.
    // An ack alone only drops valid; the data register keeps its last word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            data  <= din;
            valid <= 1'b1;
            cnt   <= cnt + 1'b1;
        end else if (ack && valid) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_12.sv
// Registered 1:2 demultiplexer (inverse of mux_21).
// The word on demux_in is steered into the slot picked by sel.
// The top level only decodes sel into per-slot loads and muxes in_ready.
module demux_12
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int CNT_W = DEMUX_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    demux_12_if.slave  bus
);

    logic [NUM_SLOTS-1:0]            load;
    logic [NUM_SLOTS-1:0]            ack;
    logic [NUM_SLOTS-1:0]            valid;
    logic [NUM_SLOTS-1:0][WIDTH-1:0] data;
    logic [NUM_SLOTS-1:0][CNT_W-1:0] cnt;
    logic                            in_ready;

    assign ack = {bus.out_ack1, bus.out_ack0};

    // The selected slot can accept when it is empty or is being drained this cycle.
    // in_ready deliberately ignores in_valid.
    always_comb begin
        in_ready = 1'b0;
        if (bus.sel == SLOT1) in_ready = ~valid[1] | ack[1];
        else                  in_ready = ~valid[0] | ack[0];
    end

    genvar k;
    generate
        for (k = 0; k < NUM_SLOTS; k++) begin : g_slot
            assign load[k] = bus.in_valid & in_ready & (bus.sel == 1'(k));

            demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (load[k]),
                .ack   (ack[k]),
                .din   (bus.demux_in),
                .data  (data[k]),
                .valid (valid[k]),
                .cnt   (cnt[k])
            );
        end
    endgenerate

    assign bus.in_ready   = in_ready;
    assign bus.demux_out0 = data[0];
    assign bus.demux_out1 = data[1];
    assign bus.out_valid0 = valid[0];
    assign bus.out_valid1 = valid[1];
    assign bus.cnt0       = cnt[0];
    assign bus.cnt1       = cnt[1];

endmodule

// File: tb/tb_demux_12.sv
// Directed bench for demux_12.
// A slot-level reference model is checked against the DUT on every falling edge.
// Literal expectations at key points pin down the model itself.
module tb_demux_12;

    logic clk = 1'b0;
    logic rst_n;

    int vectors    = 0;
    int miscompares = 0;

    demux_12_if #(.WIDTH(4), .CNT_W(8)) bus ();

    demux_12 #(.WIDTH(4), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what each slot must hold, from the handshake rules.
    int  m_data  [2];
    bit  m_valid [2];
    int  m_cnt   [2];
    bit  started = 1'b0;

    function automatic bit exp_ready();
        int s = int'(bus.sel);
        bit a = (s == 1) ? bus.out_ack1 : bus.out_ack0;
        return !m_valid[s] || a;
    endfunction

    always @(posedge clk) begin
        bit rdy, acks[2];
        acks[0] = bus.out_ack0;
        acks[1] = bus.out_ack1;
        if (!rst_n) begin
            started = 1'b1;
            for (int s = 0; s < 2; s++) begin
                m_data[s] = 0; m_valid[s] = 0; m_cnt[s] = 0;
            end
        end else if (started) begin
            rdy = exp_ready();
            for (int s = 0; s < 2; s++) begin
                if (bus.in_valid && rdy && int'(bus.sel) == s) begin
                    m_data[s]  = int'(bus.demux_in);
                    m_valid[s] = 1'b1;
                    m_cnt[s]   = (m_cnt[s] + 1) % 256;
                end else if (acks[s]) begin
                    m_valid[s] = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("m_out0",   int'(bus.demux_out0), m_data[0]);
            chk("m_out1",   int'(bus.demux_out1), m_data[1]);
            chk("m_valid0", int'(bus.out_valid0), int'(m_valid[0]));
            chk("m_valid1", int'(bus.out_valid1), int'(m_valid[1]));
            chk("m_cnt0",   int'(bus.cnt0),       m_cnt[0]);
            chk("m_cnt1",   int'(bus.cnt1),       m_cnt[1]);
            chk("m_ready",  int'(bus.in_ready),   int'(exp_ready()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.demux_in = 4'd14;
        bus.sel      = 1'b0;
        bus.out_ack0 = 1'b0;
        bus.out_ack1 = 1'b0;

        // 1: reset wins over a pending in_valid
        step(); step();
        chk("rst_out0", int'(bus.demux_out0), 0);
        chk("rst_out1", int'(bus.demux_out1), 0);
        chk("rst_v0",   int'(bus.out_valid0), 0);
        chk("rst_v1",   int'(bus.out_valid1), 0);
        chk("rst_cnt0", int'(bus.cnt0), 0);
        chk("rst_cnt1", int'(bus.cnt1), 0);

        // 2: single word into slot0
        rst_n = 1'b1;
        #1 chk("t2_ready", int'(bus.in_ready), 1);
        step();
        bus.in_valid = 1'b0;
        chk("t2_out0", int'(bus.demux_out0), 14);
        chk("t2_v0",   int'(bus.out_valid0), 1);
        chk("t2_cnt0", int'(bus.cnt0), 1);
        chk("t2_v1",   int'(bus.out_valid1), 0);

        // 3: slot0 full blocks, slot1 accepts
        bus.sel = 1'b0; bus.demux_in = 4'd2; bus.in_valid = 1'b1;
        #1 chk("t3_ready_blk", int'(bus.in_ready), 0);
        step();
        chk("t3_out0_hold", int'(bus.demux_out0), 14);
        chk("t3_cnt0_hold", int'(bus.cnt0), 1);
        bus.sel = 1'b1;
        #1 chk("t3_ready_s1", int'(bus.in_ready), 1);
        step();
        bus.in_valid = 1'b0;
        chk("t3_out1", int'(bus.demux_out1), 2);
        chk("t3_v1",   int'(bus.out_valid1), 1);
        chk("t3_cnt1", int'(bus.cnt1), 1);

        // 4: ack and accept together on slot0
        bus.sel = 1'b0; bus.demux_in = 4'd5; bus.in_valid = 1'b1; bus.out_ack0 = 1'b1;
        #1 chk("t4_ready", int'(bus.in_ready), 1);
        step();
        bus.in_valid = 1'b0; bus.out_ack0 = 1'b0;
        chk("t4_out0", int'(bus.demux_out0), 5);
        chk("t4_v0",   int'(bus.out_valid0), 1);
        chk("t4_cnt0", int'(bus.cnt0), 2);

        // plain consume of slot1, then ack on an empty slot
        bus.out_ack1 = 1'b1;
        step();
        chk("ack_v1",   int'(bus.out_valid1), 0);
        chk("ack_out1", int'(bus.demux_out1), 2);
        step();
        chk("ack_empty_v1",  int'(bus.out_valid1), 0);
        chk("ack_empty_cnt", int'(bus.cnt1), 1);
        bus.out_ack1 = 1'b0;

        // 5: 256 back-to-back accepts into slot1 with ack held; slot0 acked alongside
        bus.sel = 1'b1; bus.out_ack1 = 1'b1; bus.in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.demux_in = 4'(i);
            bus.out_ack0 = (i == 0);
            #1 chk("t5_ready", int'(bus.in_ready), 1);
            step();
            if (i == 254) chk("t5_wrap0", int'(bus.cnt1), 0);
        end
        bus.in_valid = 1'b0; bus.out_ack1 = 1'b0; bus.out_ack0 = 1'b0;
        chk("t5_cnt1", int'(bus.cnt1), 1);
        chk("t5_out1", int'(bus.demux_out1), 15);
        chk("t5_v1",   int'(bus.out_valid1), 1);
        chk("t5_v0",   int'(bus.out_valid0), 0);
        chk("t5_out0", int'(bus.demux_out0), 5);

        // 6: reset with both slots valid, then stray acks
        bus.sel = 1'b0; bus.demux_in = 4'd9; bus.in_valid = 1'b1;
        step();
        chk("t6_v0_pre", int'(bus.out_valid0), 1);
        bus.demux_in = 4'd3; bus.out_ack0 = 1'b1; rst_n = 1'b0;
        step();
        chk("t6_v0",   int'(bus.out_valid0), 0);
        chk("t6_v1",   int'(bus.out_valid1), 0);
        chk("t6_cnt0", int'(bus.cnt0), 0);
        chk("t6_cnt1", int'(bus.cnt1), 0);
        chk("t6_out0", int'(bus.demux_out0), 0);
        rst_n = 1'b1; bus.in_valid = 1'b0; bus.out_ack0 = 1'b1; bus.out_ack1 = 1'b1;
        step();
        chk("t6_post_v0",  int'(bus.out_valid0), 0);
        chk("t6_post_v1",  int'(bus.out_valid1), 0);
        chk("t6_post_out1", int'(bus.demux_out1), 0);
        chk("t6_post_cnt0", int'(bus.cnt0), 0);
        bus.out_ack0 = 1'b0; bus.out_ack1 = 1'b0;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
